// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op encodings, FSM states and counter sizing.
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  function automatic int cnt_w(input int w, input int m);
    int x;
    x = (w > m) ? w : m;
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring shift-subtract divider datapath.
// One quotient bit per step; sign and divide-by-zero fix-up on the outputs.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);

  logic [WIDTH-1:0] r, q, d, a_raw;
  logic             neg_q, neg_r, dz;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   shifted, diff;

  assign a_neg   = sgn & a[WIDTH-1];
  assign b_neg   = sgn & b[WIDTH-1];
  assign mag_a   = a_neg ? -a : a;
  assign mag_b   = b_neg ? -b : b;
  assign shifted = {r, q[WIDTH-1]};
  assign diff    = shifted - {1'b0, d};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r     <= '0;
      q     <= '0;
      d     <= '0;
      a_raw <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
    end else if (load) begin
      r     <= '0;
      q     <= mag_a;
      d     <= mag_b;
      a_raw <= a;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      dz    <= (b == '0);
    end else if (step) begin
      // borrow clear means the trial subtract fits: keep it
      q <= {q[WIDTH-2:0], ~diff[WIDTH]};
      r <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end
  end

  assign quo = dz ? '1 : (neg_q ? -q : q);
  assign rem = dz ? a_raw : (neg_r ? -r : r);

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Owns the FSM, product holding register and issue handshake.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_w(WIDTH, MULT_CYCLES);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] ext_a, ext_b, product;
  logic               accept, mul_sgn, div_load;
  logic [WIDTH-1:0]   quo, rem;

  assign accept   = start & ~busy;
  assign mul_sgn  = (op == MDU_MULT);
  assign div_load = accept & ((op == MDU_DIV) | (op == MDU_DIVU));

  // sign- or zero-extend so one 2W multiply serves both forms
  assign ext_a   = {{WIDTH{mul_sgn & A[WIDTH-1]}}, A};
  assign ext_b   = {{WIDTH{mul_sgn & B[WIDTH-1]}}, B};
  assign product = ext_a * ext_b;

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk   (clk),
    .reset (reset),
    .load  (div_load),
    .step  (state == DIV),
    .sgn   (op == MDU_DIV),
    .a     (A),
    .b     (B),
    .quo   (quo),
    .rem   (rem)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      prod  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            unique case (op)
              MDU_MULT, MDU_MULTU: begin
                prod  <= product;
                cnt   <= CW'(MULT_CYCLES - 1);
                state <= MUL;
                busy  <= 1'b1;
              end
              MDU_DIV, MDU_DIVU: begin
                cnt   <= CW'(WIDTH - 1);
                state <= DIV;
                busy  <= 1'b1;
              end
              MDU_MTHI: hi <= A;
              MDU_MTLO: lo <= A;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (cnt == '0) begin
            {hi, lo} <= prod;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DIV: begin
          if (cnt == '0) state <= FIX;
          else cnt <= cnt - CW'(1);
        end
        FIX: begin
          hi    <= rem;
          lo    <= quo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter.
// WIDTH=32, MULT_CYCLES=5.
module tb_mdu_iter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] hi, lo;

  int pass;
  int total;

  mdu_iter #(.WIDTH(32), .MULT_CYCLES(5)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = 32'hA5A5A5A5;
    B     = 32'h0;
  endtask

  // leaves the bench at the negedge where busy has dropped
  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b0;
    op    = 3'd0;
    A     = '0;
    B     = '0;
    #3 reset = 1'b1;
    #1;
    total++;
    if ({hi, lo, busy, done} !== 66'b0)
      $display("FAIL reset_outs got hi=%h lo=%h busy=%b done=%b want 0", hi, lo, busy, done);
    else pass++;
    @(negedge clk);
    reset = 1'b0;
    issue(3'd4, 32'h12345678, 32'h0);
    total++;
    if (hi !== 32'h12345678) $display("FAIL mthi_hi got %h want 12345678", hi);
    else pass++;
    total++;
    if (busy !== 1'b0) $display("FAIL mthi_busy got %b want 0", busy);
    else pass++;
    @(negedge clk);
    total++;
    if (done !== 1'b0) $display("FAIL mthi_done got %b want 0", done);
    else pass++;
  endtask

  task automatic test_mult;
    int n;
    issue(3'd0, 32'hFFFFFFFD, 32'd5);
    total++;
    if (hi !== 32'h12345678) $display("FAIL mult_hi_stable got %h want 12345678", hi);
    else pass++;
    wait_idle(n);
    total++;
    if (n != 5) $display("FAIL mult_busy_cycles got %0d want 5", n);
    else pass++;
    total++;
    if (done !== 1'b1) $display("FAIL mult_done got %b want 1", done);
    else pass++;
    total++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1)
      $display("FAIL mult_result got %h_%h want ffffffff_fffffff1", hi, lo);
    else pass++;
    @(negedge clk);
    total++;
    if (done !== 1'b0) $display("FAIL mult_done_pulse got %b want 0", done);
    else pass++;
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle(n);
    total++;
    if (n != 5) $display("FAIL multu_busy_cycles got %0d want 5", n);
    else pass++;
    total++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001)
      $display("FAIL multu_result got %h_%h want fffffffe_00000001", hi, lo);
    else pass++;
  endtask

  task automatic test_div;
    int n;
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    total++;
    if (n != 33) $display("FAIL div_busy_cycles got %0d want 33", n);
    else pass++;
    total++;
    if (done !== 1'b1) $display("FAIL div_done got %b want 1", done);
    else pass++;
    total++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD)
      $display("FAIL div_result got hi=%h lo=%h want ffffffff fffffffd", hi, lo);
    else pass++;
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    total++;
    if (hi !== 32'h00000001 || lo !== 32'h7FFFFFFC)
      $display("FAIL divu_result got hi=%h lo=%h want 00000001 7ffffffc", hi, lo);
    else pass++;
  endtask

  task automatic test_div_edge;
    int n;
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    total++;
    if (hi !== 32'h0 || lo !== 32'h80000000)
      $display("FAIL div_min_neg1 got hi=%h lo=%h want 00000000 80000000", hi, lo);
    else pass++;
    issue(3'd3, 32'h00001234, 32'h0);
    wait_idle(n);
    total++;
    if (n != 33) $display("FAIL divz_busy_cycles got %0d want 33", n);
    else pass++;
    total++;
    if (hi !== 32'h00001234 || lo !== 32'hFFFFFFFF)
      $display("FAIL divu_by_zero got hi=%h lo=%h want 00001234 ffffffff", hi, lo);
    else pass++;
    issue(3'd2, 32'hFFFFFFF0, 32'h0);
    wait_idle(n);
    total++;
    if (hi !== 32'hFFFFFFF0 || lo !== 32'hFFFFFFFF)
      $display("FAIL div_by_zero got hi=%h lo=%h want fffffff0 ffffffff", hi, lo);
    else pass++;
  endtask

  task automatic test_back_to_back;
    int n;
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    repeat (2) @(negedge clk);
    start = 1'b1;
    op    = 3'd0;
    A     = 32'd9;
    B     = 32'd9;
    @(posedge clk);
    #1;
    op = 3'd5;
    A  = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(n);
    total++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD)
      $display("FAIL busy_ignore got hi=%h lo=%h want ffffffff fffffffd", hi, lo);
    else pass++;
    total++;
    if (done !== 1'b1) $display("FAIL busy_ignore_done got %b want 1", done);
    else pass++;
    start = 1'b1;
    op    = 3'd0;
    A     = 32'd6;
    B     = 32'hFFFFFFF9;
    @(posedge clk);
    #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b1) $display("FAIL b2b_accept got busy=%b want 1", busy);
    else pass++;
    wait_idle(n);
    total++;
    if (n != 5) $display("FAIL b2b_busy_cycles got %0d want 5", n);
    else pass++;
    total++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFD6)
      $display("FAIL b2b_result got %h_%h want ffffffff_ffffffd6", hi, lo);
    else pass++;
  endtask

  task automatic test_reset_mid;
    int n;
    issue(3'd2, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({hi, lo, busy, done} !== 66'b0)
      $display("FAIL reset_mid got hi=%h lo=%h busy=%b done=%b want 0", hi, lo, busy, done);
    else pass++;
    @(negedge clk);
    reset = 1'b0;
    issue(3'd3, 32'd100, 32'd7);
    wait_idle(n);
    total++;
    if (n != 33) $display("FAIL post_reset_cycles got %0d want 33", n);
    else pass++;
    total++;
    if (hi !== 32'd2 || lo !== 32'd14)
      $display("FAIL post_reset_divu got hi=%0d lo=%0d want 2 14", hi, lo);
    else pass++;
  endtask

  task automatic test_reserved;
    issue(3'd6, 32'h55555555, 32'h1);
    total++;
    if (busy !== 1'b0 || hi !== 32'd2 || lo !== 32'd14)
      $display("FAIL reserved_op got busy=%b hi=%h lo=%h want 0 2 14", busy, hi, lo);
    else pass++;
    issue(3'd5, 32'hCAFEF00D, 32'h0);
    total++;
    if (lo !== 32'hCAFEF00D || hi !== 32'd2)
      $display("FAIL mtlo got hi=%h lo=%h want 2 cafef00d", hi, lo);
    else pass++;
  endtask

  initial begin
    pass  = 0;
    total = 0;
    test_reset();
    test_mult();
    test_div();
    test_div_edge();
    test_back_to_back();
    test_reset_mid();
    test_reserved();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised multiply/divide unit with HI/LO registers; the multi-cycle companion to the single-cycle ALU in the EX stage.
- Executes MULT/MULTU (fixed configurable latency) and DIV/DIVU (iterative restoring shift-subtract), plus MTHI/MTLO.
- Exposes busy so hazard logic can stall MFHI/MFLO and new MDU ops.

Parameters:
- WIDTH, 32, operand/HI/LO width; even and >= 4.
- MULT_CYCLES, 5, cycles from accepted multiply to HI/LO update; >= 1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  issue request, sampled on a clk edge
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
- A  in  WIDTH  rs operand (dividend/multiplicand)
- B  in  WIDTH  rt operand (divisor/multiplier)
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse: HI/LO just updated by MULT/DIV
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async): hi=0, lo=0, busy=0, done=0, state IDLE, counter 0. Reset mid-operation aborts it; HI/LO return to 0.
- States: IDLE, MUL, DIV, FIX.
- Accept: start=1 && busy=0 at edge E. If busy=1, start is ignored; no queueing.
- Reserved op: ignored, no state change.
- MTHI/MTLO: hi (or lo) <= A at edge E. No busy, no done.
- MULT/MULTU at E:
  - Full 2*WIDTH product latched (signed or unsigned); state MUL, counter=MULT_CYCLES-1.
  - busy=1 for exactly MULT_CYCLES cycles.
  - At edge E+MULT_CYCLES: {hi,lo} <= product, busy->0, done=1 for one cycle.
  - MULT_CYCLES=1: update at E+1.
- DIV/DIVU at E:
  - Latch magnitudes (abs for DIV, raw for DIVU) and result signs; state DIV, counter=WIDTH-1.
  - One quotient bit per cycle for WIDTH cycles, then FIX for one cycle.
  - At edge E+WIDTH+1: hi <= remainder, lo <= quotient, done=1, busy->0.
  - busy high for WIDTH+1 cycles.
- Signed division:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - MIN/-1: lo=MIN, hi=0, no trap.
- Divide by zero (B=0, both ops): same latency; hi=A (dividend as issued), lo=all ones.
- HI/LO are stable during busy. The in-flight operation overwrites both at completion.
- Back-to-back: in the done cycle busy=0, so a start is accepted that cycle.
- done never asserts for MTHI/MTLO.
- Operands are latched at E; later A/B changes have no effect.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_MULT..MDU_MTLO
  - state enum IDLE/MUL/DIV/FIX
  - counter-width function clog2(max(WIDTH, MULT_CYCLES))
- Natural sub-module: div_iter.
  - Holds the restoring shift-subtract datapath: remainder/quotient registers, step enable, sign fix-up.
  - mdu_iter owns the FSM, multiply holding register, HI/LO and handshake.

Test Plan:
1. reset asserted mid-cycle with no clock edge -> hi=lo=0, busy=done=0 immediately. MTHI A=0x12345678 -> hi=0x12345678 next edge, busy stays 0.
2. MULT A=0xFFFFFFFD (-3), B=5 (WIDTH=32, MULT_CYCLES=5):
   - busy high 5 cycles.
   - At E+5: hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulse.
   - MULTU A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
3. DIV A=0xFFFFFFF9 (-7), B=2:
   - busy 33 cycles.
   - At E+33: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - DIVU same operands -> lo=0x7FFFFFFC, hi=0x00000001.
4. DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU A=0x1234, B=0 -> hi=0x1234, lo=0xFFFFFFFF after 33 cycles.
5. Busy interaction:
   - Start DIV; at E+3 issue MULT and MTLO (start=1) -> both ignored; DIV result correct.
   - New MULT issued in the done cycle -> accepted, completes 5 cycles later.
6. Reset asserted at E+10 of a DIV -> outputs 0 asynchronously. After release, DIVU 100/7 -> lo=14, hi=2.
